// File: rtl/server_pkg.sv
// Shared types and frame-layout helpers for multi_user_server.
package server_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AUTH    = 2'd1,
    WAIT_OP = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // Frame layout, MSB first: {key, op_code[1:0], data}
  function automatic int frame_w(input int key_w, input int data_w);
    return key_w + 2 + data_w;
  endfunction

  function automatic int op_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int key_lsb(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/multi_user_server_rr_arbiter.sv
// Round-robin pick: first pending index strictly after last_i, wrapping modulo N_USERS.
module rr_arbiter #(
  parameter int N_USERS = 4,
  parameter int IW      = $clog2(N_USERS)
) (
  input  logic [N_USERS-1:0] pending_i,
  input  logic [IW-1:0]      last_i,
  output logic               any_req_o,
  output logic [IW-1:0]      grant_o
);

  int idx;

  assign any_req_o = |pending_i;

  // Scan from farthest to nearest so the nearest pending index is written last.
  always_comb begin
    grant_o = '0;
    idx     = 0;
    for (int k = N_USERS; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N_USERS;
      if (pending_i[idx]) grant_o = IW'(idx);
    end
  end

endmodule

// File: rtl/multi_user_server.sv
// Multi-user auth/dispatch server: round-robin over user channels, one shared OPU.
// Optional OPU wait timeout enabled by defining SERVER_OP_TIMEOUT_EN.
module multi_user_server
  import server_pkg::*;
#(
  parameter int                N_USERS        = 4,
  parameter int                DATA_W         = 8,
  parameter int                KEY_W          = 6,
  parameter logic [KEY_W-1:0]  AUTH_KEY       = 6'h2A,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [N_USERS-1:0]                            start,
  input  logic [N_USERS*frame_w(KEY_W, DATA_W)-1:0]     frame,
  output logic [N_USERS-1:0]                            auth_done,
  output logic [N_USERS-1:0]                            auth_fail,
  output logic                                          op_start,
  output logic [1:0]                                    op_code,
  output logic [DATA_W-1:0]                             data,
  input  logic                                          op_done,
  input  logic [DATA_W-1:0]                             op_result,
  output logic [DATA_W-1:0]                             result_data,
  output logic [N_USERS-1:0]                            result_valid,
  output logic [N_USERS-1:0]                            op_error
);

  localparam int FRAME_W = frame_w(KEY_W, DATA_W);
  localparam int IW      = $clog2(N_USERS);
  localparam int KL      = key_lsb(DATA_W);
  localparam int OL      = op_lsb(DATA_W);

  if (N_USERS < 2 || N_USERS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("multi_user_server: N_USERS must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  state_e                          state_q, state_d;
  logic [N_USERS-1:0]              pending_q, pending_d, cap, clr;
  logic [N_USERS-1:0][FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0]              cur_q;
  logic [IW-1:0]                   sel_q, last_q, gnt_idx;
  logic                            any_req, grant, key_ok, expire;

  logic [N_USERS-1:0] auth_done_q, auth_done_d, auth_fail_q, auth_fail_d;
  logic [N_USERS-1:0] result_valid_q, result_valid_d;
  logic               op_start_q, op_start_d;
  logic [1:0]         op_code_q, op_code_d;
  logic [DATA_W-1:0]  data_q, data_d, result_data_q, result_data_d;

  rr_arbiter #(.N_USERS(N_USERS), .IW(IW)) u_arb (
    .pending_i (pending_q),
    .last_i    (last_q),
    .any_req_o (any_req),
    .grant_o   (gnt_idx)
  );

  assign grant  = (state_q == IDLE) && any_req;
  assign key_ok = (cur_q[KL +: KEY_W] == AUTH_KEY);

  // A start landing on the grant edge of its own channel re-queues (set wins).
  always_comb begin
    clr = '0;
    if (grant) clr[gnt_idx] = 1'b1;
    cap       = start & (~pending_q | clr);
    pending_d = (pending_q & ~clr) | cap;
  end

`ifdef SERVER_OP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_USERS-1:0] op_error_q, op_error_d;

  assign cnt_d    = (state_q == WAIT_OP) ? cnt_q + 1'b1 : '0;
  assign expire   = (state_q == WAIT_OP) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign op_error = op_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_error_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      op_error_q <= op_error_d;
    end
  end
`else
  assign expire   = 1'b0;
  assign op_error = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = AUTH;
      AUTH:    state_d = key_ok ? WAIT_OP : IDLE;
      WAIT_OP: if (op_done || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    auth_done_d    = '0;
    auth_fail_d    = '0;
    op_start_d     = 1'b0;
    result_valid_d = '0;
    op_code_d      = op_code_q;
    data_d         = data_q;
    result_data_d  = result_data_q;
`ifdef SERVER_OP_TIMEOUT_EN
    op_error_d     = '0;
`endif
    case (state_q)
      AUTH: begin
        if (key_ok) begin
          auth_done_d[sel_q] = 1'b1;
          op_start_d         = 1'b1;
          op_code_d          = cur_q[OL +: 2];
          data_d             = cur_q[DATA_W-1:0];
        end else begin
          auth_fail_d[sel_q] = 1'b1;
        end
      end
      WAIT_OP: begin
        // op_done wins over a same-cycle expiry
        if (op_done) begin
          result_valid_d[sel_q] = 1'b1;
          result_data_d         = op_result;
        end
`ifdef SERVER_OP_TIMEOUT_EN
        else if (expire) op_error_d[sel_q] = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      frame_q        <= '0;
      cur_q          <= '0;
      sel_q          <= '0;
      last_q         <= IW'(N_USERS - 1);
      auth_done_q    <= '0;
      auth_fail_q    <= '0;
      op_start_q     <= 1'b0;
      op_code_q      <= '0;
      data_q         <= '0;
      result_data_q  <= '0;
      result_valid_q <= '0;
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < N_USERS; i++)
        if (cap[i]) frame_q[i] <= frame[i*FRAME_W +: FRAME_W];
      // Snapshot the granted frame so a re-queued start cannot disturb AUTH.
      if (grant) begin
        sel_q  <= gnt_idx;
        last_q <= gnt_idx;
        cur_q  <= frame_q[gnt_idx];
      end
      auth_done_q    <= auth_done_d;
      auth_fail_q    <= auth_fail_d;
      op_start_q     <= op_start_d;
      op_code_q      <= op_code_d;
      data_q         <= data_d;
      result_data_q  <= result_data_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign auth_done    = auth_done_q;
  assign auth_fail    = auth_fail_q;
  assign op_start     = op_start_q;
  assign op_code      = op_code_q;
  assign data         = data_q;
  assign result_data  = result_data_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_multi_user_server.sv
// Directed scoreboard bench for multi_user_server (4 users, 8-bit data, 6-bit key).
module tb_multi_user_server;

  localparam int NU = 4;
  localparam int FW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NU-1:0]   start;
  logic [NU*FW-1:0] frame;
  logic [NU-1:0]   auth_done, auth_fail, result_valid, op_error;
  logic            op_start, op_done;
  logic [1:0]      op_code;
  logic [7:0]      data, op_result, result_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         user;
    bit         ok;
    logic [1:0] op;
    logic [7:0] d;
  } exp_t;
  exp_t sbq[$];

  multi_user_server #(
    .N_USERS(NU), .DATA_W(8), .KEY_W(6), .AUTH_KEY(6'h2A), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame(frame),
    .auth_done(auth_done), .auth_fail(auth_fail),
    .op_start(op_start), .op_code(op_code), .data(data),
    .op_done(op_done), .op_result(op_result),
    .result_data(result_data), .result_valid(result_valid), .op_error(op_error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] opu(input logic [1:0] op, input logic [7:0] d);
    case (op)
      2'b00:   return d + 8'h11;
      2'b01:   return d - 8'h01;
      2'b10:   return d << 1;
      default: return d;
    endcase
  endfunction

  // Load a user's frame slice; optionally record the expected service.
  task automatic req(input int u, input logic [5:0] k, input logic [1:0] op,
                     input logic [7:0] d, input bit push);
    exp_t e;
    frame[u*FW +: FW] = {k, op, d};
    if (push) begin
      e.user = u; e.ok = (k == 6'h2A); e.op = op; e.d = d;
      sbq.push_back(e);
    end
  endtask

  task automatic pulse(input logic [NU-1:0] m);
    @(negedge clk); start = m;
    @(negedge clk); start = '0;
  endtask

  // Wait for the next auth pulse, check it against the scoreboard head, run the OPU.
  task automatic serve(input int lat, input bit use_res, input logic [7:0] res, output int n);
    exp_t e;
    logic [7:0] r;
    n = 1;
    while (auth_done == '0 && auth_fail == '0 && n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60) begin chk("auth_wait_bound", 32'd0, 32'd1); return; end
    if (sbq.size() == 0) begin chk("sb_underflow", 32'd0, 32'd1); return; end
    e = sbq.pop_front();
    if (e.ok) begin
      r = use_res ? res : opu(e.op, e.d);
      chk("auth_done", auth_done, 32'(1 << e.user));
      chk("auth_fail_quiet", auth_fail, 0);
      chk("op_start", op_start, 1);
      chk("op_code", op_code, e.op);
      chk("op_data", data, e.d);
      @(negedge clk);
      chk("op_start_pulse", op_start, 0);
      chk("auth_done_pulse", auth_done, 0);
      repeat (lat - 1) @(negedge clk);
      op_done = 1'b1; op_result = r;
      chk("op_code_hold", op_code, e.op);
      chk("op_data_hold", data, e.d);
      @(negedge clk); op_done = 1'b0;
      chk("result_valid", result_valid, 32'(1 << e.user));
      chk("result_data", result_data, r);
      chk("op_error_quiet", op_error, 0);
      @(negedge clk);
      chk("result_valid_pulse", result_valid, 0);
    end else begin
      chk("auth_fail", auth_fail, 32'(1 << e.user));
      chk("auth_done_quiet", auth_done, 0);
      chk("op_start_quiet", op_start, 0);
      @(negedge clk);
      chk("auth_fail_pulse", auth_fail, 0);
      chk("op_start_after_fail", op_start, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_auth_done"}, auth_done, 0);
    chk({tag, "_auth_fail"}, auth_fail, 0);
    chk({tag, "_op_start"}, op_start, 0);
    chk({tag, "_op_code"}, op_code, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_result_data"}, result_data, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_op_error"}, op_error, 0);
  endtask

  initial begin
    int n;
    int noise;
    rst_n = 1'b0; start = '0; frame = '0; op_done = 1'b0; op_result = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Burst A: all four at once from reset -> 0,1,2,3
    req(0, 6'h2A, 2'b00, 8'h01, 1); req(1, 6'h2A, 2'b01, 8'h80, 1);
    req(2, 6'h2A, 2'b10, 8'hC3, 1); req(3, 6'h2A, 2'b11, 8'h5A, 1);
    pulse(4'b1111);
    for (int i = 0; i < 4; i++) serve(2, 0, 8'h00, n);

    // Burst B: order resumes from 0
    req(0, 6'h2A, 2'b11, 8'hF0, 1); req(1, 6'h2A, 2'b10, 8'h7F, 1);
    req(2, 6'h2A, 2'b01, 8'h00, 1); req(3, 6'h2A, 2'b00, 8'hFF, 1);
    pulse(4'b1111);
    for (int i = 0; i < 4; i++) serve(1, 0, 8'h00, n);

    // Single user 0, OPU answers 3 cycles after op_start; check start->auth latency
    req(0, 6'h2A, 2'b01, 8'h33, 1);
    pulse(4'b0001);
    serve(3, 1, 8'h10, n);
    chk("start_to_auth_latency", n, 3);

    // Bad key on user 2
    req(2, 6'h15, 2'b00, 8'h44, 1);
    pulse(4'b0100);
    serve(2, 0, 8'h00, n);
    chk("fail_to_idle_no_result", result_valid, 0);

    // Wrap-around: last=2, pending {3,0} -> 3 then 0
    req(0, 6'h2A, 2'b00, 8'h10, 0); req(3, 6'h2A, 2'b10, 8'h21, 1);
    req(0, 6'h2A, 2'b00, 8'h10, 1);
    pulse(4'b1001);
    for (int i = 0; i < 2; i++) serve(2, 0, 8'h00, n);

    // last=0, pending {1,2} -> 1 then 2
    req(1, 6'h2A, 2'b01, 8'h02, 1); req(2, 6'h2A, 2'b11, 8'h99, 1);
    pulse(4'b0110);
    for (int i = 0; i < 2; i++) serve(2, 0, 8'h00, n);

    // last=2: users 0,1 -> 0 first; second start on pending user 1 is dropped
    req(0, 6'h2A, 2'b10, 8'h0F, 1); req(1, 6'h2A, 2'b10, 8'h5C, 1);
    pulse(4'b0011);
    req(1, 6'h2A, 2'b00, 8'hFF, 0);
    start = 4'b0010;
    @(negedge clk); start = '0;
    for (int i = 0; i < 2; i++) serve(2, 0, 8'h00, n);
    noise = 0;
    repeat (10) begin
      @(negedge clk);
      if (auth_done != '0 || auth_fail != '0) noise++;
    end
    chk("dup_start_no_second_service", noise, 0);

    // Reset during WAIT_OP for user 2 while user 3 is pending
    req(2, 6'h2A, 2'b00, 8'h12, 0); req(3, 6'h2A, 2'b00, 8'h34, 0);
    pulse(4'b1100);
    n = 0;
    while (op_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("reset_test_op_start_seen", op_start, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midop_reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); op_done = 1'b1; op_result = 8'hEE;
    @(negedge clk); op_done = 1'b0;
    noise = 0;
    repeat (20) begin
      if (result_valid != '0 || auth_done != '0 || auth_fail != '0 || op_start) noise++;
      @(negedge clk);
    end
    chk("post_reset_silence", noise, 0);

    // Start on the grant edge of the same channel is queued (new frame served next)
    req(2, 6'h2A, 2'b01, 8'hA1, 1);
    pulse(4'b0100);
    req(2, 6'h2A, 2'b11, 8'hB2, 1);
    start = 4'b0100;
    @(negedge clk); start = '0;
    for (int i = 0; i < 2; i++) serve(2, 0, 8'h00, n);

`ifdef SERVER_OP_TIMEOUT_EN
    // last=2: users 0,1 -> 0 times out, late op_done ignored, then 1 served
    req(0, 6'h2A, 2'b00, 8'h66, 0); req(1, 6'h2A, 2'b11, 8'h77, 1);
    pulse(4'b0011);
    n = 0;
    while (op_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("to_op_start_seen", op_start, 1);
    chk("to_auth_user0", auth_done, 4'b0001);
    n = 0;
    do begin @(negedge clk); n++; end while (op_error == '0 && n < 20);
    chk("to_delay", n, 8);
    chk("to_op_error", op_error, 4'b0001);
    chk("to_no_result", result_valid, 0);
    op_done = 1'b1; op_result = 8'hDD;
    @(negedge clk); op_done = 1'b0;
    chk("to_op_error_pulse", op_error, 0);
    chk("to_late_done_ignored", result_valid, 0);
    serve(2, 0, 8'h00, n);
`endif

    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
